fp_32_max_row_buffer: RTL and testbench



---
 rtl/fp_32_max_row_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_fp_32_max_row_buffer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_32_max_row_buffer.sv
// fp_32_max_row_buffer
// Row sequencer around the FP32 max compare tree. Stores one softmax row
// (a stream of OP_NUM-lane FP32 vectors) while forwarding each vector to the
// tree, waits for the tree's final running max, then replays the stored row
// downstream with every beat tagged by that maximum.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_*                upstream row stream (valid/ready, last marks row end)
//   tree_data/valid     vector forwarded to the compare tree
//   tree_en/tree_rst_n  tree enable and active-low running-max clear
//   tree_max/tree_vld   tree running max and its valid pulse
//   out_*               replayed row stream tagged with the row maximum
//   err_overflow        sticky flag: a row was cut at DEPTH entries
module fp_32_max_row_buffer #(
  parameter int OP_NUM     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OP_NUM*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [OP_NUM*DATA_WIDTH-1:0] tree_data,
  output logic                         tree_valid,
  output logic                         tree_en,
  output logic                         tree_rst_n,
  input  logic [DATA_WIDTH-1:0]        tree_max,
  input  logic                         tree_vld,
  output logic [OP_NUM*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]        out_max,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         err_overflow
);

  localparam int VEC_W = OP_NUM * DATA_WIDTH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_FILL   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPLAY = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [VEC_W-1:0]        mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [PTR_W-1:0]        rsp_cnt_r;
  logic [PTR_W-1:0]        row_len_r;
  logic [DATA_WIDTH-1:0]   max_r;
  logic                    err_r;

  logic                    accept_s;
  logic                    row_end_s;
  logic                    final_rsp_s;
  logic                    rd_last_s;
  logic                    fire_s;

  // Handshake and row-boundary decodes shared by the FSM and the datapath.
  always_comb begin
    accept_s    = (state_r == ST_FILL) && in_valid;
    // A row ends on in_last or when the last buffer entry is taken.
    row_end_s   = accept_s && (in_last || (wr_ptr_r == PTR_LAST));
    // The tree answers once per accepted vector; the row_len-th answer is final.
    final_rsp_s = (state_r == ST_WAIT) && tree_vld && (rsp_cnt_r == (row_len_r - PTR_ONE));
    rd_last_s   = (rd_ptr_r == (row_len_r - PTR_ONE));
    fire_s      = (state_r == ST_REPLAY) && out_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        state_nxt_s = ST_FILL;
      end
      ST_FILL: begin
        if (row_end_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_WAIT: begin
        if (final_rsp_s) begin
          state_nxt_s = ST_REPLAY;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_REPLAY: begin
        if (fire_s && rd_last_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_REPLAY;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Output decode; replay outputs read straight from the buffer so they hold while stalled.
  always_comb begin
    in_ready   = 1'b0;
    tree_valid = 1'b0;
    tree_en    = 1'b0;
    tree_rst_n = 1'b1;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = {VEC_W{1'b0}};
    out_max    = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        tree_rst_n = 1'b0;
      end
      ST_FILL: begin
        in_ready   = 1'b1;
        tree_en    = 1'b1;
        tree_valid = in_valid;
      end
      ST_WAIT: begin
        tree_en = 1'b1;
      end
      ST_REPLAY: begin
        out_valid = 1'b1;
        out_last  = rd_last_s;
        out_data  = mem_r[rd_ptr_r[IDX_W-1:0]];
        out_max   = max_r;
      end
      default: begin
        tree_rst_n = 1'b0;
      end
    endcase
  end

  assign tree_data    = in_data;
  assign err_overflow = err_r;

  // Row buffer, pointers, response counter, captured max and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      rsp_cnt_r <= PTR_ZERO;
      row_len_r <= PTR_ZERO;
      max_r     <= {DATA_WIDTH{1'b0}};
      err_r     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {VEC_W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_CLEAR: begin
          wr_ptr_r  <= PTR_ZERO;
          rd_ptr_r  <= PTR_ZERO;
          rsp_cnt_r <= PTR_ZERO;
          row_len_r <= PTR_ZERO;
        end
        ST_FILL: begin
          if (accept_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= in_data;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (in_last) begin
              row_len_r <= wr_ptr_r + PTR_ONE;
            end else if (wr_ptr_r == PTR_LAST) begin
              // Truncate: the following vector is treated as a new row.
              row_len_r <= PTR_DEPTH;
              err_r     <= 1'b1;
            end
          end
          if (tree_vld) begin
            rsp_cnt_r <= rsp_cnt_r + PTR_ONE;
          end
        end
        ST_WAIT: begin
          if (tree_vld) begin
            rsp_cnt_r <= rsp_cnt_r + PTR_ONE;
          end
          if (final_rsp_s) begin
            max_r <= tree_max;
          end
        end
        ST_REPLAY: begin
          if (fire_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_32_max_row_buffer.sv
// Self-checking bench for fp_32_max_row_buffer: behavioural compare-tree model,
// row-level scoreboard, directed scenarios followed by randomized rows.
module tb_fp_32_max_row_buffer;

  localparam int OP_NUM   = 4;
  localparam int DW       = 32;
  localparam int DEPTH    = 16;
  localparam int VEC_W    = OP_NUM * DW;
  localparam int TREE_LAT = $clog2(OP_NUM) + 1;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  logic             clk = 1'b0;
  logic             rst;
  logic [VEC_W-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [VEC_W-1:0] tree_data;
  logic             tree_valid;
  logic             tree_en;
  logic             tree_rst_n;
  logic [DW-1:0]    tree_max;
  logic             tree_vld;
  logic [VEC_W-1:0] out_data;
  logic [DW-1:0]    out_max;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             err_overflow;

  fp_32_max_row_buffer #(.OP_NUM(OP_NUM), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tree_data(tree_data), .tree_valid(tree_valid), .tree_en(tree_en), .tree_rst_n(tree_rst_n),
    .tree_max(tree_max), .tree_vld(tree_vld),
    .out_data(out_data), .out_max(out_max), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks_n = 0;
  int errors_n = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- FP32 ordering helpers (no NaNs are generated) ----------
  function automatic logic [31:0] fkey(input logic [31:0] f);
    return f[31] ? ~f : (f | 32'h80000000);
  endfunction

  function automatic logic [31:0] fmax2(input logic [31:0] a, input logic [31:0] b);
    return (fkey(a) >= fkey(b)) ? a : b;
  endfunction

  function automatic logic [31:0] vmax(input logic [VEC_W-1:0] v);
    logic [31:0] m = NEG_INF;
    for (int i = 0; i < OP_NUM; i++) m = fmax2(m, v[i*DW +: DW]);
    return m;
  endfunction

  function automatic logic [31:0] rand_lane();
    logic [7:0] e = 8'($urandom_range(0, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < OP_NUM; i++) v[i*DW +: DW] = rand_lane();
    return v;
  endfunction

  // ---------------- compare tree model ------------------------------------
  bit        pv [TREE_LAT];
  bit [31:0] pm [TREE_LAT];
  bit [31:0] run_max;
  assign tree_vld = pv[TREE_LAT-1];
  assign tree_max = pm[TREE_LAT-1];

  always @(posedge clk) begin
    if (tree_rst_n === 1'b0) begin
      for (int i = 0; i < TREE_LAT; i++) begin
        pv[i] <= 1'b0;
        pm[i] <= 32'h0;
      end
      run_max <= NEG_INF;
    end else if (tree_en === 1'b1) begin
      pv[0] <= (tree_valid === 1'b1);
      pm[0] <= (tree_valid === 1'b1) ? fmax2(run_max, vmax(tree_data)) : run_max;
      if (tree_valid === 1'b1) run_max <= fmax2(run_max, vmax(tree_data));
      for (int i = 1; i < TREE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pm[i] <= pm[i-1];
      end
    end
  end

  // ---------------- row-level reference model -----------------------------
  typedef struct {
    logic [VEC_W-1:0] data;
    logic [31:0]      mx;
    bit               last;
  } beat_t;

  beat_t            exp_q[$];
  logic [VEC_W-1:0] cur_row[$];
  bit               exp_err = 1'b0;
  int               last_acc_cyc = 0;

  task automatic model_accept(input logic [VEC_W-1:0] d, input bit last);
    logic [31:0] m;
    int n;
    cur_row.push_back(d);
    if (last || cur_row.size() == DEPTH) begin
      if (!last) exp_err = 1'b1;
      m = NEG_INF;
      foreach (cur_row[i]) m = fmax2(m, vmax(cur_row[i]));
      n = cur_row.size();
      for (int i = 0; i < n; i++) exp_q.push_back('{cur_row[i], m, (i == n - 1)});
      cur_row.delete();
      last_acc_cyc = cyc;
    end
  endtask

  // ---------------- downstream ready driver -------------------------------
  int rdy_mode = 0;
  int pat_idx  = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && pat_idx < 6) begin
            out_ready = pat[pat_idx];
            pat_idx++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- output monitor ----------------------------------------
  bit               prev_ov = 1'b0;
  bit               prev_stall = 1'b0;
  logic [VEC_W-1:0] held_data;
  logic [31:0]      held_max;
  bit               gap_pend = 1'b0;
  int               last_hs_cyc = 0;
  int               row_hs = 0, row_vc = 0;
  int               last_row_hs = 0, last_row_vc = 0;
  logic [31:0]      last_out_max = 32'h0;

  task automatic monitor_step();
    beat_t e;
    if (rst) return;
    if (out_valid && !prev_ov) begin
      check_eq("out_latency", 128'(cyc - last_acc_cyc), 128'(TREE_LAT + 1));
      row_hs = 0;
      row_vc = 0;
    end
    if (prev_stall) begin
      check_eq("stall_valid", 128'(out_valid), 128'(1));
      check_eq("stall_data", out_data, held_data);
      check_eq("stall_max", 128'(out_max), 128'(held_max));
    end
    if (gap_pend && cyc == last_hs_cyc + 1) begin
      check_eq("clear_tree_rst_n", 128'(tree_rst_n), 128'(0));
      check_eq("clear_in_ready", 128'(in_ready), 128'(0));
    end
    if (gap_pend && cyc == last_hs_cyc + 2) begin
      check_eq("gap_in_ready", 128'(in_ready), 128'(1));
      gap_pend = 1'b0;
    end
    if (out_valid) begin
      row_vc++;
      check_eq("ready_in_replay", 128'(in_ready), 128'(0));
    end
    if (out_valid && out_ready) begin
      check_eq("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_data", out_data, e.data);
        check_eq("out_max", 128'(out_max), 128'(e.mx));
        check_eq("out_last", 128'(out_last), 128'(e.last));
      end
      last_out_max = out_max;
      row_hs++;
      if (out_last) begin
        last_hs_cyc = cyc;
        gap_pend    = 1'b1;
        last_row_hs = row_hs;
        last_row_vc = row_vc;
      end
    end
    prev_stall = out_valid && !out_ready;
    held_data  = out_data;
    held_max   = out_max;
    prev_ov    = out_valid;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  // ---------------- stimulus tasks -----------------------------------------
  task automatic send_vec(input logic [VEC_W-1:0] d, input bit last);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!done && n < 300) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("accept_in_time", 128'(done), 128'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", 128'(n < 2000), 128'(1));
    idle(3);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    cur_row.delete();
    exp_err    = 1'b0;
    prev_ov    = 1'b0;
    prev_stall = 1'b0;
    gap_pend   = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready), 128'(0));
    check_eq("rst_tree_valid", 128'(tree_valid), 128'(0));
    check_eq("rst_tree_en", 128'(tree_en), 128'(0));
    check_eq("rst_tree_rst_n", 128'(tree_rst_n), 128'(0));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_last", 128'(out_last), 128'(0));
    check_eq("rst_out_data", out_data, 128'(0));
    check_eq("rst_out_max", 128'(out_max), 128'(0));
    check_eq("rst_err_overflow", 128'(err_overflow), 128'(0));
    @(negedge clk);
    check_eq("rst_fill_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_fill_tree_rst_n", 128'(tree_rst_n), 128'(1));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    int len;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    do_reset();

    // Single 3-vector row; final vector {1.0, -2.0, 7.5, 0.5}.
    send_vec({32'h40400000, 32'hC0A00000, 32'h40000000, 32'h3F800000}, 1'b0);
    send_vec({32'h3F000000, 32'h40C00000, 32'hBF800000, 32'h00000000}, 1'b0);
    send_vec({32'h3F000000, 32'h40F00000, 32'hC0000000, 32'h3F800000}, 1'b1);
    wait_drain();
    check_eq("t1_row_max", 128'(last_out_max), 128'(32'h40F00000));
    check_eq("t1_beats", 128'(last_row_hs), 128'(3));

    // Backpressure: ready pattern 1,0,0,1,0,1 across a 3-beat replay.
    pat_idx  = 0;
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send_vec(rand_vec(), (i == 2));
    wait_drain();
    rdy_mode = 0;
    check_eq("bp_handshakes", 128'(last_row_hs), 128'(3));
    check_eq("bp_valid_cycles", 128'(last_row_vc), 128'(6));

    // Single-vector row after in_valid gaps.
    idle(3);
    send_vec(rand_vec(), 1'b1);
    wait_drain();
    check_eq("single_beats", 128'(last_row_hs), 128'(1));

    // Back-to-back rows: A max 3.0, B max -1.0.
    send_vec({32'h3F000000, 32'hBF800000, 32'h3F800000, 32'h40400000}, 1'b0);
    send_vec({32'h00000000, 32'hC1000000, 32'h40000000, 32'h3FC00000}, 1'b1);
    send_vec({32'hC0800000, 32'hC0400000, 32'hC0000000, 32'hBF800000}, 1'b0);
    send_vec({32'hBFA00000, 32'hC0200000, 32'hC1000000, 32'hBFC00000}, 1'b1);
    wait_drain();
    check_eq("rowB_max", 128'(last_out_max), 128'(32'hBF800000));

    // Overflow: 16 vectors without in_last, 17th forms its own row.
    check_eq("ovf_before", 128'(err_overflow), 128'(exp_err));
    for (int i = 0; i < DEPTH; i++) send_vec(rand_vec(), 1'b0);
    send_vec(rand_vec(), 1'b1);
    check_eq("ovf_row1_beats", 128'(last_row_hs), 128'(DEPTH));
    check_eq("ovf_flag", 128'(err_overflow), 128'(exp_err));
    wait_drain();
    check_eq("ovf_row2_beats", 128'(last_row_hs), 128'(1));
    check_eq("ovf_sticky", 128'(err_overflow), 128'(exp_err));

    // Reset mid-FILL after 2 accepts; then a fresh 2-vector row.
    send_vec(rand_vec(), 1'b0);
    send_vec(rand_vec(), 1'b0);
    do_reset();
    send_vec(rand_vec(), 1'b0);
    send_vec(rand_vec(), 1'b1);
    wait_drain();
    check_eq("post_rst_beats", 128'(last_row_hs), 128'(2));

    // Randomized rows with input gaps and random downstream stalls.
    rdy_mode = 1;
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        send_vec(rand_vec(), (i == len - 1));
      end
    end
    wait_drain();
    rdy_mode = 0;
    check_eq("rand_err_flag", 128'(err_overflow), 128'(exp_err));
    check_eq("rand_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
